result_tx_ctrl: RTL and testbench

RESULT_TX_CTRL -- requirements
Module: result_tx_ctrl

---
 rtl/result_tx_ctrl_pkg.sv | 27 ++
 rtl/result_tx_ctrl_if.sv | 9 +
 rtl/result_tx_ctrl_byte_select.sv | 27 ++
 rtl/result_tx_ctrl.sv | 138 +++++++++++++
 tb/tb_result_tx_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/result_tx_ctrl_pkg.sv
// Shared types and sizing helpers for the result frame transmitter.
package result_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_IDLE,
        S_GAP,
        S_DONE
    } state_t;

    function automatic int nbytes(input int bits, input int size);
        return (bits * size + 7) / 8;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int ack, input int gap);
        int m;
        m = (ack > gap) ? ack : gap;
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/result_tx_ctrl_if.sv
// Byte handshake between the frame sequencer and the UART transmitter.
interface result_tx_ctrl_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;

    modport master (output tx_data, output tx_start, input tx_busy);
    modport slave  (input tx_data, input tx_start, output tx_busy);
endinterface

// File: rtl/result_tx_ctrl_byte_select.sv
// Picks byte i_idx of the flattened vector; bits past the vector read as 0.
module byte_select #(
    parameter int BITS = 18,
    parameter int SIZE = 784,
    parameter int NB   = 1764,
    parameter int IW   = 11
) (
    input  logic [BITS*SIZE-1:0] i_x,
    input  logic [IW-1:0]        i_idx,
    output logic [7:0]           o_byte
);
    localparam int W = NB * 8;

    logic [W-1:0] w_pad;

    always_comb begin
        w_pad = '0;
        w_pad[BITS*SIZE-1:0] = i_x;
    end

    always_comb begin
        o_byte = '0;
        for (int k = 0; k < NB; k++) begin
            if (i_idx == IW'(k)) o_byte = w_pad[k*8 +: 8];
        end
    end
endmodule

// File: rtl/result_tx_ctrl.sv
// Streams a flattened result vector out byte by byte through a UART handshake.
module result_tx_ctrl
    import result_tx_pkg::*;
#(
    parameter  int BITS        = 18,
    parameter  int SIZE        = 784,
    parameter  int GAP_CYCLES  = 16,
    parameter  int ACK_TIMEOUT = 1024,
    localparam int NB          = nbytes(BITS, SIZE),
    localparam int IW          = idx_w(NB)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [BITS*SIZE-1:0] x,
    result_tx_ctrl_if.master     tx,
    output logic                 busy,
    output logic [IW-1:0]        byte_idx,
    output logic                 frame_done,
    output logic                 err
);
    localparam int CW = cnt_w(ACK_TIMEOUT, GAP_CYCLES);
    localparam logic [IW-1:0] LAST = IW'(NB - 1);
    localparam logic [CW-1:0] ACK_LIM = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LIM = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t        r_state, w_next;
    logic          r_start_d;
    logic [IW-1:0] r_idx, w_idx_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic          r_err, w_err_nx;
    logic [7:0]    r_data;
    logic [7:0]    w_byte;
    logic          w_edge;
    logic          w_adv;

    assign w_edge = start & ~r_start_d;

    byte_select #(
        .BITS (BITS),
        .SIZE (SIZE),
        .NB   (NB),
        .IW   (IW)
    ) u_sel (
        .i_x    (x),
        .i_idx  (w_idx_nx),
        .o_byte (w_byte)
    );

    always_comb begin
        w_next   = r_state;
        w_idx_nx = r_idx;
        w_cnt_nx = r_cnt;
        w_err_nx = r_err;
        w_adv    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_edge && !tx.tx_busy) begin
                    w_next   = S_SEND;
                    w_idx_nx = '0;
                    w_err_nx = 1'b0;
                end
            end
            S_SEND: begin
                w_next   = S_WAIT_ACK;
                w_cnt_nx = CW'(1);
            end
            S_WAIT_ACK: begin
                if (tx.tx_busy) begin
                    w_next = S_WAIT_IDLE;
                end else if (r_cnt >= ACK_LIM) begin
                    w_next   = S_IDLE;
                    w_err_nx = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (!tx.tx_busy) begin
                    if (GAP_CYCLES == 0) begin
                        w_adv = 1'b1;
                    end else begin
                        w_next   = S_GAP;
                        w_cnt_nx = '0;
                    end
                end
            end
            S_GAP: begin
                if (r_cnt >= GAP_LIM) w_adv = 1'b1;
                else w_cnt_nx = r_cnt + CW'(1);
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_adv) begin
            if (r_idx == LAST) begin
                w_next = S_DONE;
            end else begin
                w_next   = S_SEND;
                w_idx_nx = r_idx + IW'(1);
            end
        end
        // abort wins over any launch or advance; the byte already sent stays sent
        if (abort) begin
            w_next   = S_IDLE;
            w_idx_nx = r_idx;
            w_cnt_nx = '0;
            w_err_nx = r_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_start_d <= 1'b0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_data    <= '0;
        end else begin
            r_state   <= w_next;
            r_start_d <= start;
            r_idx     <= w_idx_nx;
            r_cnt     <= w_cnt_nx;
            r_err     <= w_err_nx;
            if (w_next == S_SEND) r_data <= w_byte;
        end
    end

    assign tx.tx_start = (r_state == S_SEND);
    assign tx.tx_data  = r_data;
    assign busy        = (r_state == S_SEND) || (r_state == S_WAIT_ACK) ||
                         (r_state == S_WAIT_IDLE) || (r_state == S_GAP);
    assign byte_idx    = r_idx;
    assign frame_done  = (r_state == S_DONE);
    assign err         = r_err;
endmodule

// File: tb/tb_result_tx_ctrl.sv
// Scoreboard bench: two configurations, UART echo models, directed frames.
module tb_result_tx_ctrl;

    typedef struct {
        bit         done;
        logic [7:0] data;
        int         idx;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // DUT A: 4x4 bits, gap 2, ack timeout 8
    logic        rst_a = 1'b1, start_a = 1'b0, abort_a = 1'b0;
    logic [15:0] x_a = '0;
    logic        busy_a, done_a, err_a;
    logic [0:0]  idx_a;
    result_tx_ctrl_if ifa ();

    result_tx_ctrl #(
        .BITS(4), .SIZE(4), .GAP_CYCLES(2), .ACK_TIMEOUT(8)
    ) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .abort(abort_a),
        .x(x_a), .tx(ifa), .busy(busy_a), .byte_idx(idx_a),
        .frame_done(done_a), .err(err_a)
    );

    // DUT B: 3x5 bits (padded last byte), no gap
    logic        rst_b = 1'b1, start_b = 1'b0, abort_b = 1'b0;
    logic [14:0] x_b = '0;
    logic        busy_b, done_b, err_b;
    logic [0:0]  idx_b;
    result_tx_ctrl_if ifb ();

    result_tx_ctrl #(
        .BITS(3), .SIZE(5), .GAP_CYCLES(0), .ACK_TIMEOUT(8)
    ) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .abort(abort_b),
        .x(x_b), .tx(ifb), .busy(busy_b), .byte_idx(idx_b),
        .frame_done(done_b), .err(err_b)
    );

    // UART models: busy for 10 cycles starting 1 cycle after tx_start
    bit uart_en_a = 1'b1;
    int ucnt_a = 0, ucnt_b = 0;
    always @(posedge clk) begin
        if (ucnt_a != 0) ucnt_a <= ucnt_a - 1;
        else if (ifa.tx_start && uart_en_a) ucnt_a <= 10;
        if (ucnt_b != 0) ucnt_b <= ucnt_b - 1;
        else if (ifb.tx_start) ucnt_b <= 10;
    end
    assign ifa.tx_busy = (ucnt_a != 0);
    assign ifb.tx_busy = (ucnt_b != 0);

    ev_t qa[$];
    ev_t qb[$];
    int  dcnt_a = 0, dcnt_b = 0;
    logic [7:0] last_a = '0, last_b = '0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", nm, got, exp);
        end
    endtask

    // Monitor A
    always @(negedge clk) begin
        ev_t e;
        if (ifa.tx_start) begin
            if (qa.size() == 0) begin
                check("a_unexpected_tx_start", 32'(ifa.tx_data), 32'hFFFF_FFFF);
            end else begin
                e = qa.pop_front();
                check("a_ev_kind", 32'(e.done), 32'd0);
                check("a_tx_data", 32'(ifa.tx_data), 32'(e.data));
                check("a_byte_idx", 32'(idx_a), 32'(e.idx));
            end
            last_a = ifa.tx_data;
        end else if (busy_a) begin
            check("a_tx_data_stable", 32'(ifa.tx_data), 32'(last_a));
        end
        if (done_a) begin
            dcnt_a++;
            if (qa.size() == 0) begin
                check("a_unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                e = qa.pop_front();
                check("a_frame_done_order", 32'(e.done), 32'd1);
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        ev_t e;
        if (ifb.tx_start) begin
            if (qb.size() == 0) begin
                check("b_unexpected_tx_start", 32'(ifb.tx_data), 32'hFFFF_FFFF);
            end else begin
                e = qb.pop_front();
                check("b_ev_kind", 32'(e.done), 32'd0);
                check("b_tx_data", 32'(ifb.tx_data), 32'(e.data));
                check("b_byte_idx", 32'(idx_b), 32'(e.idx));
            end
            last_b = ifb.tx_data;
        end else if (busy_b) begin
            check("b_tx_data_stable", 32'(ifb.tx_data), 32'(last_b));
        end
        if (done_b) begin
            dcnt_b++;
            if (qb.size() == 0) begin
                check("b_unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                e = qb.pop_front();
                check("b_frame_done_order", 32'(e.done), 32'd1);
            end
        end
    end

    task automatic push_a(input bit d, input logic [7:0] b, input int i);
        ev_t e;
        e.done = d; e.data = b; e.idx = i;
        qa.push_back(e);
    endtask

    task automatic push_b(input bit d, input logic [7:0] b, input int i);
        ev_t e;
        e.done = d; e.data = b; e.idx = i;
        qb.push_back(e);
    endtask

    // start edge at one negedge; tx_start must be seen one cycle later
    task automatic launch_a(input string nm);
        @(negedge clk) start_a = 1'b0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk);
        check(nm, 32'(ifa.tx_start), 32'd1);
    endtask

    task automatic wait_idle_a(input string nm, input int lim);
        bit ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            if (!busy_a) ok = 1'b1;
        end
        check(nm, 32'(ok), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_tx_start", 32'(ifa.tx_start), 32'd0);
        check("rst_tx_data", 32'(ifa.tx_data), 32'd0);
        check("rst_byte_idx", 32'(idx_a), 32'd0);
        check("rst_frame_done", 32'(done_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);

        // basic frame
        x_a = 16'hA55A;
        push_a(0, 8'h5A, 0);
        push_a(0, 8'hA5, 1);
        push_a(1, 8'h00, 0);
        launch_a("a1_latency");
        wait_idle_a("a1_timeout", 200);
        repeat (2) @(negedge clk);
        check("a1_err", 32'(err_a), 32'd0);
        check("a1_done_cnt", 32'(dcnt_a), 32'd1);
        check("a1_queue_empty", 32'(qa.size()), 32'd0);

        // start held high for several frame lengths: only one frame
        x_a = 16'h1234;
        push_a(0, 8'h34, 0);
        push_a(0, 8'h12, 1);
        push_a(1, 8'h00, 0);
        launch_a("a2_latency");
        repeat (150) @(negedge clk);
        check("a2_done_cnt", 32'(dcnt_a), 32'd2);
        check("a2_queue_empty", 32'(qa.size()), 32'd0);
        check("a2_busy", 32'(busy_a), 32'd0);

        // ack timeout with tx_busy stuck low
        uart_en_a = 1'b0;
        x_a = 16'hC3E7;
        push_a(0, 8'hE7, 0);
        launch_a("a3_latency");
        repeat (7) @(negedge clk);
        check("a3_busy_at7", 32'(busy_a), 32'd1);
        check("a3_err_at7", 32'(err_a), 32'd0);
        @(negedge clk);
        check("a3_busy_at8", 32'(busy_a), 32'd0);
        check("a3_err_at8", 32'(err_a), 32'd1);
        repeat (20) @(negedge clk);
        check("a3_err_sticky", 32'(err_a), 32'd1);
        check("a3_queue_empty", 32'(qa.size()), 32'd0);
        uart_en_a = 1'b1;

        // abort in the gap after byte 0
        x_a = 16'hBEEF;
        push_a(0, 8'hEF, 0);
        launch_a("a4_latency");
        check("a4_err_cleared", 32'(err_a), 32'd0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 30 && ifa.tx_busy; i++) @(negedge clk);
        check("a4_uart_released", 32'(ifa.tx_busy), 32'd0);
        @(negedge clk);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        check("a4_busy_after_abort", 32'(busy_a), 32'd0);
        check("a4_err_after_abort", 32'(err_a), 32'd0);
        repeat (40) @(negedge clk);
        check("a4_done_cnt", 32'(dcnt_a), 32'd2);
        check("a4_queue_empty", 32'(qa.size()), 32'd0);

        // reset while waiting for the transmitter to go idle
        x_a = 16'h0F0F;
        push_a(0, 8'h0F, 0);
        launch_a("a5_latency");
        repeat (3) @(negedge clk);
        check("a5_pre_busy", 32'(busy_a), 32'd1);
        rst_a = 1'b1;
        start_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;
        check("a5_busy", 32'(busy_a), 32'd0);
        check("a5_tx_start", 32'(ifa.tx_start), 32'd0);
        check("a5_tx_data", 32'(ifa.tx_data), 32'd0);
        check("a5_byte_idx", 32'(idx_a), 32'd0);
        check("a5_frame_done", 32'(done_a), 32'd0);
        check("a5_err", 32'(err_a), 32'd0);
        repeat (20) @(negedge clk);
        check("a5_queue_empty", 32'(qa.size()), 32'd0);

        // padded last byte, zero gap
        x_b = 15'h7FFF;
        push_b(0, 8'hFF, 0);
        push_b(0, 8'h7F, 1);
        push_b(1, 8'h00, 0);
        @(negedge clk) start_b = 1'b1;
        @(negedge clk);
        check("b_latency", 32'(ifb.tx_start), 32'd1);
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clk);
                if (!busy_b) ok = 1'b1;
            end
            check("b_timeout", 32'(ok), 32'd1);
        end
        repeat (2) @(negedge clk);
        check("b_err", 32'(err_b), 32'd0);
        check("b_done_cnt", 32'(dcnt_b), 32'd1);
        check("b_queue_empty", 32'(qb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
